// File: rtl/rx_fifo_bank.sv
// NCH independent receive FIFOs read through one channel-selected, registered port; pops fire on rd_req rising edges.
// Optional feature macro RXFIFO_OVERWRITE_EN: a push into a full channel replaces the oldest word instead of being dropped.
module rx_fifo_bank #(
    parameter int NCH   = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [NCH-1:0]       wr_valid,
    input  logic [NCH*WIDTH-1:0] wr_data,
    input  logic [SELW-1:0]      rd_sel,
    input  logic                 rd_req,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 rd_empty,
    output logic                 rd_full,
    output logic [NCH-1:0]       ovf,
    input  logic [NCH-1:0]       ovf_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic             rd_req_q;
    logic             pop_evt;
    logic [SELW-1:0]  rd_sel_q;
    logic [NCH-1:0]   ovf_q, ovf_d;
    logic [NCH-1:0]   ch_empty, ch_full;
    logic [WIDTH-1:0] head [NCH];

    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_empty_q, rd_empty_d;
    logic             rd_full_q, rd_full_d;

    assign pop_evt = rd_req & ~rd_req_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]    cnt_q, cnt_d;
        logic             full, empty, push, pop, do_wr, ovf_evt;

        assign full  = (cnt_q == CW'(DEPTH));
        assign empty = (cnt_q == '0);
        assign push  = wr_valid[c];
        // Pops on an empty channel are silently ignored; an out-of-range rd_sel matches no channel.
        assign pop   = pop_evt && (rd_sel == SELW'(c)) && !empty;

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            do_wr    = 1'b0;
            ovf_evt  = 1'b0;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                if (!full || pop) begin
                    do_wr    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (!pop) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    ovf_evt = 1'b1;
`ifdef RXFIFO_OVERWRITE_EN
                    // Full means wr_ptr == rd_ptr, so this write lands on the oldest word.
                    do_wr    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    rd_ptr_d = rd_ptr_q + PW'(1);
`endif
                end
            end else if (pop) begin
                cnt_d = cnt_q - CW'(1);
            end
        end

        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        always_ff @(posedge clk_clk) begin
            if (do_wr && !reset_reset) begin
                mem_q[wr_ptr_q] <= wr_data[c*WIDTH +: WIDTH];
            end
        end

        assign head[c]     = mem_q[rd_ptr_q];
        assign ch_empty[c] = empty;
        assign ch_full[c]  = full;
        // An overflow in the same cycle as a clear keeps the flag set.
        assign ovf_d[c]    = (ovf_q[c] & ~ovf_clr[c]) | ovf_evt;
    end

    always_comb begin
        rd_data_d  = '0;
        rd_empty_d = 1'b1;
        rd_full_d  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_sel_q == SELW'(i)) begin
                rd_data_d  = ch_empty[i] ? '0 : head[i];
                rd_empty_d = ch_empty[i];
                rd_full_d  = ch_full[i];
            end
        end
    end

    // rd_req_q resets high so a request held through reset is not seen as a rising edge.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rd_req_q   <= 1'b1;
            rd_sel_q   <= '0;
            ovf_q      <= '0;
            rd_data_q  <= '0;
            rd_empty_q <= 1'b1;
            rd_full_q  <= 1'b0;
        end else begin
            rd_req_q   <= rd_req;
            rd_sel_q   <= rd_sel;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_empty_q <= rd_empty_d;
            rd_full_q  <= rd_full_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_empty = rd_empty_q;
    assign rd_full  = rd_full_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_rx_fifo_bank.sv
// Directed bench for rx_fifo_bank with NCH=5 so that rd_sel can address a non-existent channel.
module tb_rx_fifo_bank;

    localparam int NCH   = 5;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int SELW  = 3;

    logic                 clk_clk = 1'b0;
    logic                 reset_reset;
    logic [NCH-1:0]       wr_valid;
    logic [NCH*WIDTH-1:0] wr_data;
    logic [SELW-1:0]      rd_sel;
    logic                 rd_req;
    logic [WIDTH-1:0]     rd_data;
    logic                 rd_empty;
    logic                 rd_full;
    logic [NCH-1:0]       ovf;
    logic [NCH-1:0]       ovf_clr;

    int n_cmp = 0;
    int n_err = 0;
    int base;

    rx_fifo_bank #(.NCH(NCH), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .rd_sel     (rd_sel),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_empty   (rd_empty),
        .rd_full    (rd_full),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic [7:0] val);
        wr_valid[ch] = 1'b1;
        wr_data[ch*WIDTH +: WIDTH] = val;
        tick();
        wr_valid = '0;
    endtask

    task automatic pop();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic set_sel(input int s);
        rd_sel = SELW'(s);
        tick();
        tick();
    endtask

    initial begin
        reset_reset = 1'b1;
        wr_valid    = '0;
        wr_data     = '0;
        rd_sel      = '0;
        rd_req      = 1'b0;
        ovf_clr     = '0;
        tick();
        tick();
        chk("reset rd_data", rd_data, 0);
        chk("reset rd_empty", rd_empty, 1);
        chk("reset rd_full", rd_full, 0);
        chk("reset ovf", ovf, 0);
        reset_reset = 1'b0;
        tick();

        // Three words through channel 2 in order
        push(2, 8'h41);
        push(2, 8'h42);
        push(2, 8'h43);
        set_sel(2);
        chk("ch2 not empty", rd_empty, 0);
        chk("ch2 word0", rd_data, 8'h41);
        pop();
        chk("ch2 word1", rd_data, 8'h42);
        pop();
        chk("ch2 word2", rd_data, 8'h43);
        pop();
        chk("ch2 drained empty", rd_empty, 1);
        chk("ch2 drained data", rd_data, 0);
        for (int c = 0; c < 4; c++) begin
            if (c != 2) begin
                set_sel(c);
                chk($sformatf("ch%0d untouched empty", c), rd_empty, 1);
            end
        end

        // Seventeen pushes into channel 0
        for (int i = 0; i <= 16; i++) push(0, 8'(i));
        set_sel(0);
        chk("ch0 full", rd_full, 1);
        chk("ch0 ovf", ovf, 5'b00001);
`ifdef RXFIFO_OVERWRITE_EN
        base = 1;
`else
        base = 0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("ch0 pop %0d", i), rd_data, 32'(base + i));
            pop();
        end
        chk("ch0 empty after drain", rd_empty, 1);
        ovf_clr = 5'b00001;
        tick();
        ovf_clr = '0;
        chk("ch0 ovf cleared", ovf, 0);

        // Full channel 1: simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) push(1, 8'(8'h10 + i));
        set_sel(1);
        chk("ch1 full", rd_full, 1);
        wr_valid[1] = 1'b1;
        wr_data[1*WIDTH +: WIDTH] = 8'h55;
        rd_req = 1'b1;
        tick();
        wr_valid = '0;
        rd_req = 1'b0;
        tick();
        chk("ch1 no ovf on push+pop", ovf, 0);
        chk("ch1 still full", rd_full, 1);
        chk("ch1 head after pop", rd_data, 8'h11);
        for (int i = 1; i < DEPTH; i++) begin
            chk($sformatf("ch1 drain %0d", i), rd_data, 32'(8'h10 + i));
            pop();
        end
        chk("ch1 last word", rd_data, 8'h55);
        pop();
        chk("ch1 empty", rd_empty, 1);

        // rd_req held high across a mid-operation reset
        push(3, 8'h99);
        rd_req = 1'b1;
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        push(4, 8'h77);
        push(4, 8'h78);
        set_sel(4);
        tick();
        chk("held rd_req no pop", rd_data, 8'h77);
        rd_req = 1'b0;
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        chk("single pop after release", rd_data, 8'h78);
        tick();
        tick();
        chk("no extra pop", rd_data, 8'h78);
        set_sel(3);
        chk("reset discarded ch3", rd_empty, 1);

        // Overflow versus clear priority on channel 3
        for (int i = 0; i < DEPTH; i++) push(3, 8'(8'h30 + i));
        chk("ch3 no ovf at exactly full", ovf, 0);
        push(3, 8'h40);
        chk("ch3 ovf set", ovf, 5'b01000);
        wr_valid[3] = 1'b1;
        wr_data[3*WIDTH +: WIDTH] = 8'h41;
        ovf_clr = 5'b01000;
        tick();
        wr_valid = '0;
        ovf_clr = '0;
        chk("ch3 ovf wins over clear", ovf, 5'b01000);
        ovf_clr = 5'b01000;
        tick();
        ovf_clr = '0;
        chk("ch3 ovf cleared", ovf, 0);
        chk("ch3 full", rd_full, 1);

        // Out-of-range select
        set_sel(5);
        chk("oob rd_empty", rd_empty, 1);
        chk("oob rd_data", rd_data, 0);
        chk("oob rd_full", rd_full, 0);
        pop();
        rd_sel = 3'd7;
        pop();
        set_sel(4);
        chk("oob pop left ch4", rd_data, 8'h78);
        set_sel(3);
        chk("oob pop left ch3 full", rd_full, 1);

        // All channels pushed in one cycle
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        for (int c = 0; c < NCH; c++) wr_data[c*WIDTH +: WIDTH] = 8'(8'hA0 + c);
        wr_valid = '1;
        tick();
        wr_valid = '0;
        for (int c = 0; c < NCH; c++) begin
            set_sel(c);
            chk($sformatf("all-push ch%0d", c), rd_data, 32'(8'hA0 + c));
        end
        chk("all-push no ovf", ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
